// File: rtl/ce_slot_sequencer.sv
// Memory slot sequencer: locks onto the 4 MHz / 16 MHz enables and grants four fixed slots
// per CPU period to CPU, video and refresh. Optional spare-slot arbitration via SLOT_SPARE_EN.
module ce_slot_sequencer #(
    parameter int REFRESH_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_16mhz,
    input  logic       cpu_ce_p,
    input  logic       cpu_req,
    input  logic       vid_req,
    output logic       cpu_ack,
    output logic       vid_ack,
    output logic       mem_start,
    output logic [1:0] mem_owner,
    output logic       locked,
    output logic       phase_err
);

    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_VID  = 2'd2;
    localparam logic [1:0] OWN_REF  = 2'd3;
    localparam logic [7:0] CNT_LAST = 8'(REFRESH_DIV - 1);

    typedef enum logic {S_UNLOCKED, S_LOCKED} state_t;

    state_t     state_q, state_d;
    logic [1:0] slot_q, slot_d;
    logic       wrap_err;

    logic [7:0] refresh_cnt_q, refresh_cnt_d;
    logic       refresh_pending_q, refresh_pending_d;
    logic       refresh_wrap, refresh_clr;

    logic       phase_err_q, phase_err_d;
    logic       cpu_ack_q, cpu_ack_d;
    logic       vid_ack_q, vid_ack_d;
    logic       mem_start_q, mem_start_d;
    logic [1:0] mem_owner_q, mem_owner_d;

`ifdef SLOT_SPARE_EN
    // 0: CPU wins the next contested spare slot, 1: video wins
    logic       rr_q, rr_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_UNLOCKED;
            slot_q            <= 2'd0;
            refresh_cnt_q     <= 8'd0;
            refresh_pending_q <= 1'b0;
            phase_err_q       <= 1'b0;
            cpu_ack_q         <= 1'b0;
            vid_ack_q         <= 1'b0;
            mem_start_q       <= 1'b0;
            mem_owner_q       <= OWN_IDLE;
`ifdef SLOT_SPARE_EN
            rr_q              <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            slot_q            <= slot_d;
            refresh_cnt_q     <= refresh_cnt_d;
            refresh_pending_q <= refresh_pending_d;
            phase_err_q       <= phase_err_d;
            cpu_ack_q         <= cpu_ack_d;
            vid_ack_q         <= vid_ack_d;
            mem_start_q       <= mem_start_d;
            mem_owner_q       <= mem_owner_d;
`ifdef SLOT_SPARE_EN
            rr_q              <= rr_d;
`endif
        end
    end

    // Next-state: lock and slot tracking
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        wrap_err = 1'b0;
        if (ce_16mhz) begin
            if (cpu_ce_p) begin
                slot_d  = 2'd0;
                state_d = S_LOCKED;
            end else begin
                slot_d   = slot_q + 2'd1;
                wrap_err = (state_q == S_LOCKED) && (slot_q == 2'd3);
            end
        end
    end

    // Output decode: grants are taken from the slot being entered on this edge
    always_comb begin
        mem_owner_d = mem_owner_q;
        refresh_clr = 1'b0;
`ifdef SLOT_SPARE_EN
        rr_d        = rr_q;
`endif
        if (ce_16mhz) begin
            mem_owner_d = OWN_IDLE;
            if (state_d == S_LOCKED) begin
                case (slot_d)
                    2'd0: if (cpu_req) mem_owner_d = OWN_CPU;
                    2'd1: if (vid_req) mem_owner_d = OWN_VID;
`ifdef SLOT_SPARE_EN
                    2'd2: begin
                        if (cpu_req && vid_req) begin
                            mem_owner_d = rr_q ? OWN_VID : OWN_CPU;
                            rr_d        = ~rr_q;
                        end else if (cpu_req) begin
                            mem_owner_d = OWN_CPU;
                        end else if (vid_req) begin
                            mem_owner_d = OWN_VID;
                        end
                    end
`endif
                    2'd3: begin
                        if (refresh_pending_q) begin
                            mem_owner_d = OWN_REF;
                            refresh_clr = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        mem_start_d = ce_16mhz && (mem_owner_d != OWN_IDLE);
        cpu_ack_d   = ce_16mhz && (mem_owner_d == OWN_CPU);
        vid_ack_d   = ce_16mhz && (mem_owner_d == OWN_VID);
        phase_err_d = phase_err_q | wrap_err;
    end

    // Refresh divider; a wrap outranks a same-clk clear so no request is lost
    always_comb begin
        refresh_cnt_d = refresh_cnt_q;
        refresh_wrap  = 1'b0;
        if (cpu_ce_p) begin
            if (refresh_cnt_q == CNT_LAST) begin
                refresh_cnt_d = 8'd0;
                refresh_wrap  = 1'b1;
            end else begin
                refresh_cnt_d = refresh_cnt_q + 8'd1;
            end
        end
        if (refresh_wrap)
            refresh_pending_d = 1'b1;
        else if (refresh_clr)
            refresh_pending_d = 1'b0;
        else
            refresh_pending_d = refresh_pending_q;
    end

    assign cpu_ack   = cpu_ack_q;
    assign vid_ack   = vid_ack_q;
    assign mem_start = mem_start_q;
    assign mem_owner = mem_owner_q;
    assign locked    = (state_q == S_LOCKED);
    assign phase_err = phase_err_q;

endmodule

// File: doc/ce_slot_sequencer.md
# ce_slot_sequencer

Memory slot sequencer: the consuming end of the system clock-enable generator. It locks onto the 4 MHz CPU enable and the 16 MHz enable, divides every 4 MHz period into four fixed memory slots, and grants each slot to the CPU, video fetch or SDRAM refresh through a request/acknowledge handshake. It sits between the clock-enable generator and the SDRAM controller, driving one access-start strobe per granted slot.

## Interface
- REFRESH_DIV, 16: number of 4 MHz periods between refresh requests; legal range 2..256.
- clk  in  1  system clock; 64 MHz, 16 clk per 4 MHz period.
- reset  in  1  synchronous, active-high reset.
- ce_16mhz  in  1  16 MHz enable, one-clk pulse every 4 clk.
- cpu_ce_p  in  1  4 MHz CPU enable; always coincident with a ce_16mhz pulse.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- vid_req  in  1  video fetch request; level, held until vid_ack.
- cpu_ack  out  1  one-clk grant pulse to the CPU.
- vid_ack  out  1  one-clk grant pulse to video.
- mem_start  out  1  one-clk strobe: SDRAM access begins.
- mem_owner  out  2  owner of the current access: 0 idle, 1 CPU, 2 video, 3 refresh; held until the next slot edge.
- locked  out  1  phase lock achieved; slots are valid.
- phase_err  out  1  sticky: enable stream is out of phase.

## Operation
- Slot edge: any clk with ce_16mhz=1. Slot index `slot[1:0]`:
  - cpu_ce_p=1: slot:=0, locked:=1.
  - otherwise slot:=slot+1, wrapping 3->0.
- Before locked=1, slot edges grant nothing, and mem_start, cpu_ack and vid_ack stay 0.
- Phase check: a ce_16mhz edge that would wrap slot 3->0 without cpu_ce_p sets phase_err=1. phase_err clears only on reset. Grants continue regardless.
- Slot assignment, evaluated at the slot edge from that clk's request levels:
  - Slot 0: CPU if cpu_req, else idle.
  - Slot 1: video if vid_req, else idle.
  - Slot 2 (spare): see Configuration.
  - Slot 3: refresh if refresh_pending, else idle.
- Refresh counter:
  - 8-bit refresh_cnt increments on each cpu_ce_p.
  - On reaching REFRESH_DIV-1 it wraps to 0 and sets refresh_pending.
  - refresh_pending clears when slot 3 grants refresh.
  - A wrap and a clear in the same clk leave refresh_pending=1.
- Handshake:
  - A requester seeing ack must drop req in the clk after ack, or keep it high to request another access.
  - At most one ack per slot.
  - A req that rises in the same clk as a slot edge is served in that slot.
- Reset, including mid-access, returns every output and internal register to its reset value. No partial grant survives reset.

## Timing
- Reset values:
  - cpu_ack=0, vid_ack=0, mem_start=0, mem_owner=0, locked=0, phase_err=0.
  - slot=0, refresh_cnt=0, refresh_pending=0, spare priority=CPU.
- Latency: outputs are registered and appear exactly 1 clk after the slot edge.
  - mem_start and the ack pulse are high together for that one clk.
  - mem_owner updates on the same clk and holds for 4 clk.
- mem_start=1 if and only if the new mem_owner≠0.
- locked rises 1 clk after the first cpu_ce_p following reset.
- First grant possible is in slot 0 of that same cpu_ce_p edge.
- Worst-case CPU grant latency with the feature compiled out: 16 clk from req to ack.

## Configuration
- SLOT_SPARE_EN defined:
  - Slot 2 grants CPU or video. If only one requests, that one wins.
  - If both request, a round-robin pointer decides: CPU first after reset, and the pointer toggles after each contested grant.
- SLOT_SPARE_EN undefined:
  - Slot 2 is always idle, with mem_owner=0 and no ack.
  - The round-robin pointer is not instantiated.

## Test plan
- Reset released, cpu_ce_p every 16 clk, ce_16mhz every 4 clk, no requests -> locked=1 one clk after the first cpu_ce_p; mem_start pulses only in slot 3 once per REFRESH_DIV=16 periods, with mem_owner=3.
- cpu_req held high -> cpu_ack and mem_start pulse 1 clk after each slot-0 edge with mem_owner=1; with SLOT_SPARE_EN also after each slot-2 edge (2 acks per 16 clk).
- cpu_req and vid_req both held, SLOT_SPARE_EN -> slot 2 alternates CPU, video, CPU ...; per 16 clk, CPU gets 2 acks then 1, video 1 then 2.
- ce_16mhz injects a fifth pulse between cpu_ce_p edges -> phase_err=1 and stays 1 until reset; grants continue.
- reset asserted for 1 clk on the same clk as a slot-0 edge with cpu_req=1 -> no cpu_ack next clk; all outputs 0; locked=0 until the next cpu_ce_p.
- vid_req rises on the exact clk of a slot-1 edge -> vid_ack 1 clk later with mem_owner=2.
